// File: rtl/bmu_multicycle_if.sv
// Request/result bus for bmu_multicycle: the master issues start with operands,
// the slave answers with busy while iterating and a one-cycle done with out_S.
interface bmu_multicycle_if;
  // start is a single-cycle request sampled only in IDLE; there is no ready signal,
  // a start seen while busy or done is dropped. done qualifies out_S for exactly one
  // cycle and out_S then holds until the next done.
  logic        start;
  logic [4:0]  option;
  logic [31:0] in_X;
  logic [31:0] in_Y;
  logic        busy;
  logic        done;
  logic [31:0] out_S;

  modport master (output start, option, in_X, in_Y, input busy, done, out_S);
  modport slave  (input start, option, in_X, in_Y, output busy, done, out_S);
endinterface

// File: rtl/bmu_multicycle.sv
// Bit-serial bit-manipulation unit: CPOP/CLZ/CTZ (and CLMUL* when BMU_MC_CLMUL_EN is
// defined) evaluated one operand bit per cycle, fixed 33-cycle latency.
module bmu_multicycle (
  input  logic                   clk,
  input  logic                   rst,
  bmu_multicycle_if.slave        bus,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [4:0] OP_CLMUL  = 5'b00001;
  localparam logic [4:0] OP_CLMULH = 5'b00010;
  localparam logic [4:0] OP_CLMULR = 5'b00011;
  localparam logic [4:0] OP_CLZ    = 5'b00100;
  localparam logic [4:0] OP_CPOP   = 5'b00101;
  localparam logic [4:0] OP_CTZ    = 5'b00110;

  state_t      state;
  logic [4:0]  cnt;
  logic [4:0]  op;
  logic [31:0] x;
  logic [5:0]  res;
  logic        found;
  logic [5:0]  res_nxt;
  logic        found_nxt;
  logic [31:0] result_nxt;
  logic        op_ok;

`ifdef BMU_MC_CLMUL_EN
  logic [31:0] y;
  logic [63:0] acc;
  logic [63:0] acc_nxt;
`endif

  assign dbg_state = state;

  always_comb begin
    op_ok = (bus.option == OP_CLZ) || (bus.option == OP_CPOP) || (bus.option == OP_CTZ);
`ifdef BMU_MC_CLMUL_EN
    op_ok = op_ok || (bus.option == OP_CLMUL) || (bus.option == OP_CLMULH) ||
            (bus.option == OP_CLMULR);
`endif
  end

  // One bit step: CLZ keeps the highest set bit seen, CTZ latches the first one.
  always_comb begin
    res_nxt   = res;
    found_nxt = found;
    case (op)
      OP_CPOP: res_nxt = res + {5'b0, x[cnt]};
      OP_CLZ:  if (x[cnt]) res_nxt = 6'd31 - {1'b0, cnt};
      OP_CTZ:  if (x[cnt] && !found) begin
                 res_nxt   = {1'b0, cnt};
                 found_nxt = 1'b1;
               end
      default: ;
    endcase
  end

`ifdef BMU_MC_CLMUL_EN
  always_comb begin
    acc_nxt = acc;
    if (y[cnt]) acc_nxt = acc ^ ({32'b0, x} << cnt);
  end
`endif

  always_comb begin
    result_nxt = {26'b0, res_nxt};
`ifdef BMU_MC_CLMUL_EN
    case (op)
      OP_CLMUL:  result_nxt = acc_nxt[31:0];
      OP_CLMULH: result_nxt = acc_nxt[63:32];
      OP_CLMULR: result_nxt = acc_nxt[62:31];
      default:   ;
    endcase
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      op        <= 5'd0;
      x         <= 32'd0;
      res       <= 6'd0;
      found     <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.out_S <= 32'd0;
`ifdef BMU_MC_CLMUL_EN
      y         <= 32'd0;
      acc       <= 64'd0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          op    <= bus.option;
          x     <= bus.in_X;
          cnt   <= 5'd0;
          found <= 1'b0;
          res   <= (bus.option == OP_CPOP) ? 6'd0 : 6'd32;
`ifdef BMU_MC_CLMUL_EN
          y     <= bus.in_Y;
          acc   <= 64'd0;
`endif
          if (op_ok) begin
            state    <= RUN;
            bus.busy <= 1'b1;
          end else begin
            state     <= DONE;
            bus.done  <= 1'b1;
            bus.out_S <= 32'd0;
          end
        end
        RUN: begin
          res   <= res_nxt;
          found <= found_nxt;
          cnt   <= cnt + 5'd1;
`ifdef BMU_MC_CLMUL_EN
          acc   <= acc_nxt;
`endif
          if (cnt == 5'd31) begin
            state     <= DONE;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            bus.out_S <= result_nxt;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bmu_multicycle.md
BMU_MULTICYCLE -- requirements
Module: bmu_multicycle

Interface
REQ-001 Parameters: none; datapath fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled each rising edge.
REQ-005 option  input  5  operation code: CLMUL=5'b00001, CLMULH=5'b00010, CLMULR=5'b00011, CLZ=5'b00100, CPOP=5'b00101, CTZ=5'b00110.
REQ-006 in_X  input  32  operand X.
REQ-007 in_Y  input  32  operand Y (CLMUL* only).
REQ-008 busy  output  1  high while an operation iterates.
REQ-009 done  output  1  one-cycle result-valid pulse.
REQ-010 out_S  output  32  result; holds the last result until the next done.

Function
REQ-011 FSM states SHALL be IDLE, RUN, DONE.
REQ-012 IDLE with start=1 at an edge SHALL latch option, in_X, in_Y and the counter SHALL clear to 0.
- Supported option: state goes to RUN.
- Any other option: state goes to DONE with result 0.
REQ-013 RUN SHALL process operand bit index = counter per cycle, counter 0..31, and go to DONE after bit 31.
REQ-014 DONE SHALL drive done=1 for exactly one cycle with out_S valid, then return to IDLE.
REQ-015 busy SHALL be 1 in RUN only.
REQ-016 Latency for supported ops SHALL be fixed: start sampled at edge N; done high during cycle after edge N+32 (33 cycles). There is no early termination.
REQ-017 start SHALL be ignored in RUN and DONE; operands/option changes after capture SHALL have no effect.
REQ-018 CPOP SHALL return the number of 1 bits in X (0..32).
REQ-019 CLZ SHALL return count of leading zeros of X; X=0 gives 32.
REQ-020 CTZ SHALL return count of trailing zeros of X; X=0 gives 32.
REQ-021 CLMUL* SHALL form a 64-bit carry-less product P = XOR over i of (X<<i) where Y[i]=1, accumulated one Y bit per RUN cycle.
- CLMUL returns P[31:0].
- CLMULH returns P[63:32].
- CLMULR returns P[62:31].
REQ-022 out_S SHALL update only on the edge entering DONE.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, counter 0, busy 0, done 0, out_S 0, accumulator 0.
REQ-024 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-025 First start after rst deasserts SHALL be accepted at the next edge.

Configuration
REQ-026 Macro BMU_MC_CLMUL_EN, when defined, SHALL compile in the 64-bit accumulator and CLMUL/CLMULH/CLMULR support.
REQ-027 Without BMU_MC_CLMUL_EN:
- CLMUL/CLMULH/CLMULR SHALL be unsupported options (REQ-012: DONE next edge, out_S 0).
- CLZ/CPOP/CTZ behaviour SHALL be unchanged.

Verification
REQ-028 CPOP, X=0xF0F0_0001 -> done 33 cycles after start, out_S=9, busy high for 32 cycles.
REQ-029 CLZ X=0x0000_0000 -> out_S=32.
- CTZ X=0x0000_0100 -> out_S=8.
- CLZ X=0x0001_0000 -> out_S=15.
REQ-030 With BMU_MC_CLMUL_EN:
- CLMUL X=3, Y=3 -> out_S=0x5.
- CLMULH X=0x8000_0000, Y=2 -> out_S=0x1.
- CLMULR X=0x8000_0000, Y=2 -> out_S=0x2.
REQ-031 Back-to-back operations:
- CPOP X=0xFFFF_FFFF started.
- start pulsed with option CTZ and changed in_X at cycle 10 -> ignored; out_S=32 at done.
- Next start then accepted in IDLE.
REQ-032 rst pulsed at cycle 15 of CLZ run -> busy/done/out_S=0 immediately, no done pulse within 40 following cycles.
REQ-033 Without BMU_MC_CLMUL_EN, CLMUL start -> done one cycle after start edge, out_S=0, busy never high; option 5'b11111 -> same response.
